// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style main sequencer for the multi-cycle MIPS datapath.
// Walks one instruction at a time through FETCH/DECODE and the per-class phases,
// driving datapath enables and mux selects decoded from the current state.
//
// Memory handshake: mem_read or mem_write (together with i_or_d) is the request.
// It is raised on entry to FETCH, MEMRD or MEMWR and held stable every cycle until
// a cycle in which mem_ready is high; that cycle completes the access and the FSM
// advances on the following edge. mem_ready has no effect in any other state.
module multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic [1:0]  load_size,
   output logic [3:0]  state,
   output logic        illegal_op,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SW    = 6'h2B;

   state_t cur_state;
   state_t next_state;
   logic   retire;
   logic   illegal_next;

   // The zero flag gates the PC write in the datapath, not in this sequencer.
   logic   unused_zero;
   assign unused_zero = zero;

   assign state = cur_state;

   // State, retired-instruction counter and illegal-opcode flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state   <= S_RST;
         instr_count <= '0;
         illegal_op  <= 1'b0;
      end else begin
         cur_state  <= next_state;
         illegal_op <= illegal_next;
         if (retire) begin
            instr_count <= instr_count + 32'd1;
         end
      end
   end

   // Next-state selection, retire strobe and illegal-opcode detection.
   always_comb begin
      next_state   = cur_state;
      retire       = 1'b0;
      illegal_next = 1'b0;
      case (cur_state)
         S_RST:    next_state = S_FETCH;
         S_FETCH:  if (mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                    next_state = S_EXEC;
               OP_BEQ:                      next_state = S_BRANCH;
               OP_ADDI:                     next_state = S_ADDIEX;
               OP_LW, OP_LH, OP_LHU, OP_SW: next_state = S_MEMADR;
               OP_J:                        next_state = S_JUMP;
               default: begin
                  next_state   = S_FETCH;
                  illegal_next = 1'b1;
               end
            endcase
         end
         S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
         S_MEMWB: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         S_MEMWR: begin
            if (mem_ready) begin
               next_state = S_FETCH;
               retire     = 1'b1;
            end
         end
         S_EXEC:   next_state = S_RWB;
         S_RWB: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         S_BRANCH: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         S_ADDIEX: next_state = S_ADDIWB;
         S_ADDIWB: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         S_JUMP: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         default:  next_state = S_RST;
      endcase
   end

   // Datapath controls decoded from the current state; FETCH also gates on mem_ready.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      load_size     = 2'b00;
      case (cur_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: alu_src_b = 2'b11;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            case (opcode)
               OP_LH:   load_size = 2'b01;
               OP_LHU:  load_size = 2'b10;
               default: load_size = 2'b00;
            endcase
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: drives instruction streams with randomized memory stalls
// and compares the controller against a per-instruction phase model.
module tb_multicycle_control;

   localparam logic [3:0] ST_RST    = 4'd0;
   localparam logic [3:0] ST_FETCH  = 4'd1;
   localparam logic [3:0] ST_DECODE = 4'd2;
   localparam logic [3:0] ST_MEMADR = 4'd3;
   localparam logic [3:0] ST_MEMRD  = 4'd4;
   localparam logic [3:0] ST_MEMWB  = 4'd5;
   localparam logic [3:0] ST_MEMWR  = 4'd6;
   localparam logic [3:0] ST_EXEC   = 4'd7;
   localparam logic [3:0] ST_RWB    = 4'd8;
   localparam logic [3:0] ST_BRANCH = 4'd9;
   localparam logic [3:0] ST_ADDIEX = 4'd10;
   localparam logic [3:0] ST_ADDIWB = 4'd11;
   localparam logic [3:0] ST_JUMP   = 4'd12;

   localparam int K_R = 0, K_BEQ = 1, K_ADDI = 2, K_LOAD = 3, K_STORE = 4, K_J = 5, K_ILL = 6;
   localparam int NAGG = 17;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = 6'h00;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source, load_size;
   logic [3:0]  state;
   logic        illegal_op;
   logic [31:0] instr_count;
   logic [19:0] ctl_w;

   int checks = 0;
   int passes = 0;

   logic [3:0]  exp_q[$];
   logic        rdy_q[$];
   int unsigned exp_cnt = 0;
   logic        prev_ill = 1'b0;

   logic [3:0]  s_state;
   logic [19:0] s_ctl;
   logic        s_ill, s_rd, s_wr, s_iord, s_irw, s_pcw, s_pcwc, s_rw, s_dst, s_m2r, s_rdy;
   logic [1:0]  s_ls, s_aluop, s_src, s_srcb;
   logic [31:0] s_cnt;

   string agg_name[NAGG] = '{"mem_read_cycles", "mem_write_cycles", "i_or_d_cycles",
      "ir_write_cycles", "ir_write_without_ready", "pc_write_cycles", "pc_write_cond_cycles",
      "reg_write_cycles", "reg_dst_cycles", "mem_to_reg_cycles", "load_size_cycles",
      "load_size_value", "alu_op_sub_cycles", "alu_op_funct_cycles", "pc_source_jump_cycles",
      "illegal_op_cycles", "pc_source_aluout_cycles"};

   assign ctl_w = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, load_size};

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .load_size(load_size), .state(state),
      .illegal_op(illegal_op), .instr_count(instr_count)
   );

   // Clock generation.
   always #5 clk = ~clk;

   function automatic int klass(input logic [5:0] op);
      case (op)
         6'h00:               return K_R;
         6'h04:               return K_BEQ;
         6'h08:               return K_ADDI;
         6'h23, 6'h21, 6'h25: return K_LOAD;
         6'h2B:               return K_STORE;
         6'h02:               return K_J;
         default:             return K_ILL;
      endcase
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Phase list of one instruction with stall cycles inserted; mem_ready plan alongside.
   task automatic model_path(input logic [5:0] op, input int fs, input int ms);
      int k;
      k = klass(op);
      exp_q.delete();
      rdy_q.delete();
      for (int i = 0; i < fs; i++) begin exp_q.push_back(ST_FETCH); rdy_q.push_back(1'b0); end
      exp_q.push_back(ST_FETCH);  rdy_q.push_back(1'b1);
      exp_q.push_back(ST_DECODE); rdy_q.push_back(rnd_bit());
      case (k)
         K_R: begin
            exp_q.push_back(ST_EXEC); rdy_q.push_back(rnd_bit());
            exp_q.push_back(ST_RWB);  rdy_q.push_back(rnd_bit());
         end
         K_BEQ: begin exp_q.push_back(ST_BRANCH); rdy_q.push_back(rnd_bit()); end
         K_ADDI: begin
            exp_q.push_back(ST_ADDIEX); rdy_q.push_back(rnd_bit());
            exp_q.push_back(ST_ADDIWB); rdy_q.push_back(rnd_bit());
         end
         K_LOAD: begin
            exp_q.push_back(ST_MEMADR); rdy_q.push_back(rnd_bit());
            for (int i = 0; i < ms; i++) begin exp_q.push_back(ST_MEMRD); rdy_q.push_back(1'b0); end
            exp_q.push_back(ST_MEMRD); rdy_q.push_back(1'b1);
            exp_q.push_back(ST_MEMWB); rdy_q.push_back(rnd_bit());
         end
         K_STORE: begin
            exp_q.push_back(ST_MEMADR); rdy_q.push_back(rnd_bit());
            for (int i = 0; i < ms; i++) begin exp_q.push_back(ST_MEMWR); rdy_q.push_back(1'b0); end
            exp_q.push_back(ST_MEMWR); rdy_q.push_back(1'b1);
         end
         K_J: begin exp_q.push_back(ST_JUMP); rdy_q.push_back(rnd_bit()); end
         default: ;
      endcase
   endtask

   // One clock cycle: inputs applied after the rising edge, outputs sampled at the falling edge.
   task automatic cycle(input logic [5:0] op, input logic rdy);
      opcode    = op;
      mem_ready = rdy;
      zero      = rnd_bit();
      @(negedge clk);
      s_state = state;   s_ctl  = ctl_w;      s_ill = illegal_op; s_cnt  = instr_count;
      s_rd    = mem_read; s_wr  = mem_write;  s_iord = i_or_d;    s_irw  = ir_write;
      s_pcw   = pc_write; s_pcwc = pc_write_cond; s_rw = reg_write; s_dst = reg_dst;
      s_m2r   = mem_to_reg; s_ls = load_size; s_aluop = alu_op;  s_src  = pc_source;
      s_srcb  = alu_src_b; s_rdy = mem_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_cnt  = 0;
      prev_ill = 1'b0;
   endtask

   // Runs one instruction and checks its phase sequence and aggregate control activity.
   task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
      int k, cyc;
      int got[NAGG];
      int want[NAGG];
      logic [3:0] e;
      logic r;
      logic [5:0] drv;
      logic [1:0] ls_or;
      k = klass(op);
      model_path(op, fs, ms);
      foreach (got[j]) got[j] = 0;
      ls_or = 2'b00;
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = rdy_q.pop_front();
         drv = (e >= ST_DECODE && e <= ST_MEMWR) ? op : 6'($urandom_range(0, 63));
         cycle(drv, r);
         checks++;
         if (s_state !== e)
            $display("FAIL state op=%02h cycle %0d: got %0d expected %0d", op, cyc, s_state, e);
         else passes++;
         if (cyc == 0) begin
            checks++;
            if (s_ill !== prev_ill)
               $display("FAIL illegal_first_cycle op=%02h: got %b expected %b", op, s_ill, prev_ill);
            else passes++;
         end
         got[0]  += int'(s_rd);
         got[1]  += int'(s_wr);
         got[2]  += int'(s_iord);
         got[3]  += int'(s_irw);
         got[4]  += int'(s_irw && !s_rdy);
         got[5]  += int'(s_pcw);
         got[6]  += int'(s_pcwc);
         got[7]  += int'(s_rw);
         got[8]  += int'(s_dst);
         got[9]  += int'(s_m2r);
         got[10] += int'(s_ls != 2'b00);
         ls_or    = ls_or | s_ls;
         got[12] += int'(s_aluop == 2'b01);
         got[13] += int'(s_aluop == 2'b10);
         got[14] += int'(s_src == 2'b10);
         got[15] += int'(s_ill);
         got[16] += int'(s_src == 2'b01);
         cyc++;
      end
      got[11] = int'(ls_or);
      want[0]  = fs + 1 + ((k == K_LOAD) ? ms + 1 : 0);
      want[1]  = (k == K_STORE) ? ms + 1 : 0;
      want[2]  = (k == K_LOAD || k == K_STORE) ? ms + 1 : 0;
      want[3]  = 1;
      want[4]  = 0;
      want[5]  = (k == K_J) ? 2 : 1;
      want[6]  = (k == K_BEQ) ? 1 : 0;
      want[7]  = (k == K_R || k == K_ADDI || k == K_LOAD) ? 1 : 0;
      want[8]  = (k == K_R) ? 1 : 0;
      want[9]  = (k == K_LOAD) ? 1 : 0;
      want[10] = (op == 6'h21 || op == 6'h25) ? 1 : 0;
      want[11] = (op == 6'h21) ? 1 : ((op == 6'h25) ? 2 : 0);
      want[12] = (k == K_BEQ) ? 1 : 0;
      want[13] = (k == K_R) ? 1 : 0;
      want[14] = (k == K_J) ? 1 : 0;
      want[15] = prev_ill ? 1 : 0;
      want[16] = (k == K_BEQ) ? 1 : 0;
      for (int j = 0; j < NAGG; j++) begin
         checks++;
         if (got[j] !== want[j])
            $display("FAIL %s op=%02h: got %0d expected %0d", agg_name[j], op, got[j], want[j]);
         else passes++;
      end
      prev_ill = (k == K_ILL);
      if (k != K_ILL) exp_cnt++;
      checks++;
      if (instr_count !== exp_cnt)
         $display("FAIL instr_count op=%02h: got %0d expected %0d", op, instr_count, exp_cnt);
      else passes++;
      checks++;
      if (state !== ST_FETCH)
         $display("FAIL next_fetch op=%02h: got %0d expected %0d", op, state, ST_FETCH);
      else passes++;
   endtask

   task automatic test_reset();
      reset_dut();
      cycle(6'h00, 1'b1);
      cycle(6'h00, 1'b1);
      #2; rst_n = 1'b0; #1;
      checks++;
      if (state !== ST_RST) $display("FAIL reset_state: got %0d expected 0", state); else passes++;
      checks++;
      if (ctl_w !== 20'h0) $display("FAIL reset_outputs: got %05h expected 00000", ctl_w); else passes++;
      checks++;
      if ({illegal_op, instr_count} !== 33'h0)
         $display("FAIL reset_count: got %0d/%b expected 0/0", instr_count, illegal_op);
      else passes++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(6'h00, 1'b1);
      checks++;
      if (s_state !== ST_RST || s_ctl !== 20'h0)
         $display("FAIL release_rst_cycle: got state %0d ctl %05h expected state 0 ctl 00000", s_state, s_ctl);
      else passes++;
      cycle(6'h00, 1'b1);
      checks++;
      if (s_state !== ST_FETCH || !s_rd || !s_irw || !s_pcw || s_iord || s_srcb !== 2'b01)
         $display("FAIL first_fetch: got state %0d ctl %05h expected fetch controls", s_state, s_ctl);
      else passes++;
   endtask

   task automatic test_rtype();
      reset_dut();
      run_instr(6'h00, 0, 0);
   endtask

   task automatic test_lh_stall();
      reset_dut();
      run_instr(6'h21, 0, 3);
   endtask

   task automatic test_sw_beq();
      reset_dut();
      run_instr(6'h2B, 0, 0);
      run_instr(6'h04, 0, 0);
   endtask

   task automatic test_illegal();
      reset_dut();
      run_instr(6'h3F, 0, 0);
      run_instr(6'h00, 0, 0);
   endtask

   task automatic test_fetch_stall();
      reset_dut();
      run_instr(6'h08, 2, 0);
      run_instr(6'h02, 1, 0);
   endtask

   task automatic test_reset_mid_stall();
      reset_dut();
      run_instr(6'h00, 0, 0);
      cycle(6'h2B, 1'b1);
      cycle(6'h2B, 1'b0);
      cycle(6'h2B, 1'b0);
      cycle(6'h2B, 1'b0);
      checks++;
      if (s_state !== ST_MEMWR || !s_wr || !s_iord)
         $display("FAIL memwr_stall: got state %0d ctl %05h expected state 6 with write", s_state, s_ctl);
      else passes++;
      mem_ready = 1'b0;
      #2; rst_n = 1'b0; #1;
      checks++;
      if (state !== ST_RST || ctl_w !== 20'h0 || illegal_op !== 1'b0)
         $display("FAIL async_reset_outputs: got state %0d ctl %05h expected 0 00000", state, ctl_w);
      else passes++;
      checks++;
      if (instr_count !== 32'd0) $display("FAIL async_reset_count: got %0d expected 0", instr_count);
      else passes++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(6'h2B, 1'b1);
      checks++;
      if (s_state !== ST_RST) $display("FAIL post_reset_rst: got %0d expected 0", s_state); else passes++;
      cycle(6'h2B, 1'b1);
      checks++;
      if (s_state !== ST_FETCH) $display("FAIL post_reset_fetch: got %0d expected 1", s_state); else passes++;
   endtask

   task automatic test_random();
      logic [5:0] legal[8];
      logic [5:0] op;
      legal = '{6'h00, 6'h04, 6'h08, 6'h23, 6'h21, 6'h25, 6'h2B, 6'h02};
      reset_dut();
      repeat (60) begin
         if ($urandom_range(0, 7) == 0) begin
            op = 6'($urandom_range(0, 63));
            if (klass(op) != K_ILL) op = 6'h3F;
         end else begin
            op = legal[$urandom_range(0, 7)];
         end
         run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
   endtask

   // Test sequence and final report.
   initial begin
      test_reset();
      test_rtype();
      test_lh_stall();
      test_sw_beq();
      test_illegal();
      test_fetch_stall();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS main controller that sequences the shared datapath (single memory, single ALU, IR, PC, register file) one instruction at a time. It decodes the opcode latched in the IR and walks a Moore-style FSM, driving datapath enables and mux selects each cycle. Memory accesses stall on a ready handshake. It replaces the single-cycle opcode decoder as the top-level sequencer of the processor.

## Interface
- No parameters.
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Opcode  in  6  IR[31:26], valid from DECODE onward.
- Zero  in  1  ALU zero flag; consumed by datapath PC-write gating.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- LoadSize  out  2  00 word, 01 half signed, 10 half unsigned.
- State  out  4  current state code, for debug.
- IllegalOp  out  1  one-cycle pulse on unsupported opcode.
- InstrCount  out  32  retired-instruction count.

## Operation
- States and codes: RST 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12.
- Every output not listed for a state is 0.
- RST: all outputs 0; next FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal MemReady. Stays until MemReady=1, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by Opcode:
  - 0x00 -> EXEC
  - 0x04 -> BRANCH
  - 0x08 -> ADDIEX
  - 0x23, 0x21, 0x25, 0x2B -> MEMADR
  - 0x02 -> JUMP
  - any other opcode -> FETCH with IllegalOp=1 for that cycle; not counted as retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMWR if Opcode=0x2B, else MEMRD.
- MEMRD: MemRead=1, IorD=1. Stays until MemReady, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. LoadSize is 00 for 0x23, 01 for 0x21, 10 for 0x25. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Stays until MemReady, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- LoadSize holds its MEMWB value only in MEMWB; it is 00 elsewhere.
- Retire: InstrCount increments by 1 on the clock edge leaving MEMWB, MEMWR (with MemReady), RWB, BRANCH, ADDIWB or JUMP. The count wraps from 0xFFFFFFFF to 0.

## Timing
- State, InstrCount and the IllegalOp flag are registers. Outputs are decoded from State. IRWrite and PCWrite in FETCH are additionally combinational on MemReady.
- Latencies with MemReady tied to 1, FETCH to next FETCH:
  - R-type 4 cycles
  - lw/lh/lhu 5 cycles
  - sw 4 cycles
  - beq 3 cycles
  - addi 4 cycles
  - j 3 cycles
  - illegal 2 cycles
- Each cycle MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. During a stall, MemRead/MemWrite and the address select stay asserted and stable.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- Rst_n low at any time, including mid-stall: State goes to RST immediately, all outputs go to 0, and InstrCount goes to 0. The first FETCH occurs one cycle after Rst_n deasserts.
- Opcode is sampled only in DECODE and MEMADR/MEMWB; its value in other states has no effect.

## Test plan
- Reset, then Opcode=0x00 with MemReady=1: State sequence 0,1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8. InstrCount=1.
- lh (0x21) with MemReady low 3 cycles in MEMRD: MemRead=1 and IorD=1 held for 4 cycles. MEMWB shows LoadSize=01. Total 8 cycles.
- sw (0x2B) then beq (0x04): MemWrite=1 for exactly 1 cycle, then BRANCH shows PCWriteCond=1, ALUOp=01, PCSource=01. InstrCount=2 after 7 cycles.
- Opcode=0x3F: DECODE goes to FETCH with a single-cycle IllegalOp=1. InstrCount is unchanged. No RegWrite or MemWrite occurs.
- FETCH with MemReady=0 for 2 cycles then 1: IRWrite and PCWrite pulse for exactly 1 cycle, coincident with MemReady.
- Rst_n pulsed low during a MEMWR stall: State=0 and all outputs 0 asynchronously, InstrCount=0. FETCH follows one cycle after release.
